// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage of a 5-stage LoongArch pipeline.
//
// Keeps the PC and picks the next PC from the sequential path or a branch
// redirect. Drives the synchronous instruction SRAM (one-cycle read latency).
// Buffers the returned word while decode is stalled. Hands {pc, inst} to
// decode over a valid/allow-in handshake.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   ID_Allow_in       decode can accept this cycle
//   br_bus[33:0]      {br_taken, br_target[31:0], stall}; stall is unused here
//   IF_to_ID_Valid    IF holds a valid, non-squashed instruction
//   IF_to_ID_Bus      {pc[31:0], inst[31:0]}
//   inst_sram_*       instruction SRAM request/response; addr == nextpc
//   IF_Adef           (IF_ADEF_CHECK_EN only) misaligned-PC fetch fault
//
// Optional feature macro: IF_ADEF_CHECK_EN. When it is defined, misaligned
// fetch PCs are flagged on IF_Adef, their SRAM read is suppressed, and NOP_INST
// is delivered in place of the instruction.

module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h1bff_fffc,
   parameter logic [31:0] NOP_INST = 32'h0340_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ID_Allow_in,
   input  logic [33:0] br_bus,
   output logic        IF_to_ID_Valid,
   output logic [63:0] IF_to_ID_Bus,
   output logic        inst_sram_en,
   output logic [3:0]  inst_sram_we,
   output logic [31:0] inst_sram_addr,
   output logic [31:0] inst_sram_wdata,
   input  logic [31:0] inst_sram_rdata
`ifdef IF_ADEF_CHECK_EN
   ,
   output logic        IF_Adef
`endif
);

   logic        br_taken;
   logic [31:0] br_target;
   logic        unused_stall;

   logic [31:0] pc_q;
   logic        if_valid_q;
   logic [31:0] ibuf_q;
   logic        ibuf_valid_q;

   logic        preif_valid;
   logic [31:0] seq_pc;
   logic [31:0] nextpc;
   logic        if_allow_in;
   logic        ibuf_capture;
   logic        ibuf_clear;
   logic [31:0] inst;

   assign br_taken     = br_bus[33];
   assign br_target    = br_bus[32:1];
   assign unused_stall = br_bus[0];

   // Pre-IF: next fetch address.
   assign preif_valid = ~reset;
   assign seq_pc      = pc_q + 32'd4;
   assign nextpc      = br_taken ? br_target : seq_pc;

   // A redirect forces allow-in so the target fetch is never lost.
   assign if_allow_in = ~if_valid_q | br_taken | ID_Allow_in;

`ifdef IF_ADEF_CHECK_EN
   assign inst_sram_en = preif_valid & if_allow_in & (nextpc[1:0] == 2'b00);
`else
   assign inst_sram_en = preif_valid & if_allow_in;
`endif

   assign inst_sram_we    = 4'h0;
   assign inst_sram_addr  = nextpc;
   assign inst_sram_wdata = 32'h0;

   // The instruction sitting in IF during a redirect is wrong-path.
   assign IF_to_ID_Valid = if_valid_q & ~br_taken;

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q       <= RESET_PC;
         if_valid_q <= 1'b0;
      end else if (if_allow_in) begin
         pc_q       <= nextpc;
         if_valid_q <= preif_valid;
      end
   end

   // SRAM data is only valid the cycle after the request; hold it once decode
   // stalls, because the SRAM output is not retained while en is low.
   assign ibuf_capture = if_valid_q & ~ID_Allow_in & ~ibuf_valid_q & ~br_taken;
   assign ibuf_clear   = reset | br_taken | (IF_to_ID_Valid & ID_Allow_in);

   always_ff @(posedge clk) begin
      if (ibuf_clear) begin
         ibuf_valid_q <= 1'b0;
      end else if (ibuf_capture) begin
         ibuf_valid_q <= 1'b1;
      end
      if (ibuf_capture) begin
         ibuf_q <= inst_sram_rdata;
      end
   end

`ifdef IF_ADEF_CHECK_EN
   assign IF_Adef = if_valid_q & (pc_q[1:0] != 2'b00);
   assign inst    = IF_Adef ? NOP_INST : (ibuf_valid_q ? ibuf_q : inst_sram_rdata);
`else
   localparam logic [31:0] unused_nop_inst = NOP_INST;
   assign inst = ibuf_valid_q ? ibuf_q : inst_sram_rdata;
`endif

   assign IF_to_ID_Bus = {pc_q, inst};

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit. The SRAM model returns addr ^ A5A5A5A5 one
// cycle after an enabled read and garbage (DEADBEEF) after an idle cycle.
// Inputs are driven at the falling edge; outputs are checked 1 time unit later.
`timescale 1ns/1ps

module tb_if_fetch_unit;

   localparam logic [31:0] Key = 32'ha5a5_a5a5;

   logic        clk = 1'b0;
   logic        reset;
   logic        ID_Allow_in;
   logic [33:0] br_bus;
   logic        IF_to_ID_Valid;
   logic [63:0] IF_to_ID_Bus;
   logic        inst_sram_en;
   logic [3:0]  inst_sram_we;
   logic [31:0] inst_sram_addr;
   logic [31:0] inst_sram_wdata;
   logic [31:0] inst_sram_rdata = 32'h0;
`ifdef IF_ADEF_CHECK_EN
   logic        IF_Adef;
`endif

   int checks   = 0;
   int failures = 0;

   if_fetch_unit dut (
      .clk             (clk),
      .reset           (reset),
      .ID_Allow_in     (ID_Allow_in),
      .br_bus          (br_bus),
      .IF_to_ID_Valid  (IF_to_ID_Valid),
      .IF_to_ID_Bus    (IF_to_ID_Bus),
      .inst_sram_en    (inst_sram_en),
      .inst_sram_we    (inst_sram_we),
      .inst_sram_addr  (inst_sram_addr),
      .inst_sram_wdata (inst_sram_wdata),
      .inst_sram_rdata (inst_sram_rdata)
`ifdef IF_ADEF_CHECK_EN
      ,
      .IF_Adef         (IF_Adef)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (inst_sram_en) inst_sram_rdata <= inst_sram_addr ^ Key;
      else              inst_sram_rdata <= 32'hdead_beef;
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Drive one cycle of inputs at the falling edge, then let combinational
   // outputs settle before checks.
   task automatic drive(input logic rst, input logic allow, input logic taken,
                        input logic [31:0] target);
      @(negedge clk);
      reset       = rst;
      ID_Allow_in = allow;
      br_bus      = {taken, target, 1'b0};
      #1;
   endtask

   initial begin
      reset       = 1'b1;
      ID_Allow_in = 1'b0;
      br_bus      = '0;

      // Reset
      drive(1'b1, 1'b1, 1'b0, 32'h0);
      drive(1'b1, 1'b1, 1'b0, 32'h0);
      check_eq("rst_valid", 64'(IF_to_ID_Valid), 64'd0);
      check_eq("rst_en", 64'(inst_sram_en), 64'd0);
      check_eq("rst_addr", 64'(inst_sram_addr), 64'h1c00_0000);
      check_eq("rst_we_wdata", {28'h0, inst_sram_we, inst_sram_wdata}, 64'd0);

      // First fetch after reset release
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      check_eq("first_en", 64'(inst_sram_en), 64'd1);
      check_eq("first_addr", 64'(inst_sram_addr), 64'h1c00_0000);
      check_eq("first_valid", 64'(IF_to_ID_Valid), 64'd0);

      // Streaming
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      check_eq("s0_valid", 64'(IF_to_ID_Valid), 64'd1);
      check_eq("s0_bus", IF_to_ID_Bus, 64'h1c00_0000_b9a5_a5a5);
      check_eq("s0_addr", 64'(inst_sram_addr), 64'h1c00_0004);
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      check_eq("s1_bus", IF_to_ID_Bus, 64'h1c00_0004_b9a5_a5a1);

      // Three-cycle decode stall at 1c000008
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 1'b0, 32'h0);
         check_eq("stall_valid", 64'(IF_to_ID_Valid), 64'd1);
         check_eq("stall_bus", IF_to_ID_Bus, 64'h1c00_0008_b9a5_a5ad);
         check_eq("stall_en", 64'(inst_sram_en), 64'd0);
      end
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      check_eq("release_bus", IF_to_ID_Bus, 64'h1c00_0008_b9a5_a5ad);
      check_eq("release_en", 64'(inst_sram_en), 64'd1);
      check_eq("release_addr", 64'(inst_sram_addr), 64'h1c00_000c);
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      check_eq("after_release", IF_to_ID_Bus, 64'h1c00_000c_b9a5_a5a9);

      // Redirect while IF holds 1c000010
      drive(1'b0, 1'b1, 1'b1, 32'h1c00_0100);
      check_eq("br_squash", 64'(IF_to_ID_Valid), 64'd0);
      check_eq("br_addr", 64'(inst_sram_addr), 64'h1c00_0100);
      check_eq("br_en", 64'(inst_sram_en), 64'd1);
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      check_eq("br_tgt_valid", 64'(IF_to_ID_Valid), 64'd1);
      check_eq("br_tgt_bus", IF_to_ID_Bus, 64'h1c00_0100_b9a5_a4a5);

      // Redirect in the 2nd cycle of a stall
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      check_eq("st_br_bus", IF_to_ID_Bus, 64'h1c00_0104_b9a5_a4a1);
      check_eq("st_br_en0", 64'(inst_sram_en), 64'd0);
      drive(1'b0, 1'b0, 1'b1, 32'h1c00_0200);
      check_eq("st_br_squash", 64'(IF_to_ID_Valid), 64'd0);
      check_eq("st_br_en", 64'(inst_sram_en), 64'd1);
      check_eq("st_br_addr", 64'(inst_sram_addr), 64'h1c00_0200);
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      check_eq("st_br_valid", 64'(IF_to_ID_Valid), 64'd1);
      check_eq("st_br_tgt", IF_to_ID_Bus, 64'h1c00_0200_b9a5_a7a5);

      // PC wrap
      drive(1'b0, 1'b1, 1'b1, 32'hffff_fffc);
      check_eq("wrap_br_addr", 64'(inst_sram_addr), 64'hffff_fffc);
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      check_eq("wrap_bus", IF_to_ID_Bus, 64'hffff_fffc_5a5a_5a59);
      check_eq("wrap_addr", 64'(inst_sram_addr), 64'h0000_0000);
      check_eq("wrap_en", 64'(inst_sram_en), 64'd1);
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      check_eq("wrap_next", IF_to_ID_Bus, 64'h0000_0000_a5a5_a5a5);

      // Reset mid-stall with a pending redirect
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      check_eq("mid_stall_bus", IF_to_ID_Bus, 64'h0000_0004_a5a5_a5a1);
      drive(1'b1, 1'b0, 1'b1, 32'h1c00_0300);
      check_eq("mid_rst_en", 64'(inst_sram_en), 64'd0);
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      check_eq("mid_rst_valid", 64'(IF_to_ID_Valid), 64'd0);
      check_eq("mid_rst_addr", 64'(inst_sram_addr), 64'h1c00_0000);
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      check_eq("post_rst_addr", 64'(inst_sram_addr), 64'h1c00_0000);
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      check_eq("post_rst_bus", IF_to_ID_Bus, 64'h1c00_0000_b9a5_a5a5);

`ifdef IF_ADEF_CHECK_EN
      // Misaligned branch target
      drive(1'b0, 1'b1, 1'b1, 32'h1c00_0102);
      check_eq("adef_en", 64'(inst_sram_en), 64'd0);
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      check_eq("adef_flag", 64'(IF_Adef), 64'd1);
      check_eq("adef_valid", 64'(IF_to_ID_Valid), 64'd1);
      check_eq("adef_bus", IF_to_ID_Bus, 64'h1c00_0102_0340_0000);
      drive(1'b0, 1'b1, 1'b1, 32'h1c00_0000);
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      check_eq("adef_clear", 64'(IF_Adef), 64'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
